// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types and helpers for the scoreboarded register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int POPCNT_MAXW   = 1024;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

    // Callers zero-pad narrower vectors into the fixed-width argument.
    function automatic int unsigned popcount(input logic [POPCNT_MAXW-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POPCNT_MAXW; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : per-register pending bits and registered pending count
// Revision           : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_valid_i,
    input  logic [AW-1:0]           iss_rd_i,
    input  logic [NWR-1:0]          we_i,
    input  logic [NWR-1:0][AW-1:0]  wa_i,
    input  logic                    flush_i,
    output logic [NREGS-1:0]        pend_o,
    output logic [AW:0]             pend_cnt_o
);

    logic [NREGS-1:0]       pend_q;
    logic [NREGS-1:0]       pend_d;
    logic [AW:0]            cnt_q;
    logic [AW:0]            cnt_d;
    logic [POPCNT_MAXW-1:0] w_pend_pad;

    // Later assignments win: clear, then set, then flush over everything.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int i = 0; i < NWR; i++) begin
                if (we_i[i] && (wa_i[i] == AW'(r))) begin
                    pend_d[r] = 1'b0;
                end
            end
            if (iss_valid_i && (iss_rd_i == AW'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
        if (flush_i) begin
            pend_d = '0;
        end
    end

    always_comb begin
        w_pend_pad              = '0;
        w_pend_pad[NREGS-1:0]   = pend_d;
        cnt_d                   = (AW+1)'(popcount(w_pend_pad));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o     = pend_q;
    assign pend_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : multi-port integer register file with RAW-hazard scoreboard
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int              XLEN      = XLEN_DEFAULT,
    parameter  int              NREGS     = NREGS_DEFAULT,
    parameter  int              NRD       = 2,
    parameter  int              NWR       = 2,
    parameter  logic [XLEN-1:0] RESET_VAL = '0,
    parameter  bit              BYPASS    = 1'b1,
    localparam int              AW        = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0][AW-1:0]    ra_i,
    output logic [NRD-1:0][XLEN-1:0]  rdata_o,
    output logic [NRD-1:0]            rpend_o,
    input  logic [NWR-1:0]            we_i,
    input  logic [NWR-1:0][AW-1:0]    wa_i,
    input  logic [NWR-1:0][XLEN-1:0]  wd_i,
    input  logic                      iss_valid_i,
    input  logic [AW-1:0]             iss_rd_i,
    input  logic                      flush_i,
    output logic [AW:0]               pend_cnt_o
);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [NREGS-1:0] w_pend;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .we_i        (we_i),
        .wa_i        (wa_i),
        .flush_i     (flush_i),
        .pend_o      (w_pend),
        .pend_cnt_o  (pend_cnt_o)
    );

    // Ports are scanned in ascending order so the highest index wins a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                rf_q[r] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we_i[i] && (wa_i[i] != '0)) begin
                    rf_q[wa_i[i]] <= wd_i[i];
                end
            end
        end
    end

    // A bypassed write is the producer completing, so the hazard is resolved.
    always_comb begin
        rdata_o = '0;
        rpend_o = '0;
        for (int j = 0; j < NRD; j++) begin
            rdata_o[j] = rf_q[ra_i[j]];
            rpend_o[j] = w_pend[ra_i[j]];
            if (BYPASS) begin
                for (int i = 0; i < NWR; i++) begin
                    if (we_i[i] && (wa_i[i] == ra_i[j])) begin
                        rdata_o[j] = wd_i[i];
                        rpend_o[j] = 1'b0;
                    end
                end
            end
            if (ra_i[j] == '0) begin
                rdata_o[j] = '0;
                rpend_o[j] = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
